unified_buffer_arb: RTL
=======================

Name: unified_buffer_arb

Overview:
- Second-generation unified buffer: NUM_BANKS single-row-per-cycle banks behind two global-address request ports with valid/ready handshakes.
- Low-order address interleaving maps each address to one bank.
- Round-robin arbitration resolves same-bank conflicts between the ports.
- Read data is returned after a parametrised fixed latency with a valid strobe.
- Sits between the DMA/controller side and the systolic-array feeders, replacing per-bank raw addressing.

Parameters:
- DATA_WIDTH, 8, word width in bits (signed data).
- NUM_BANKS, 16, bank count; power of two, at least 2.
- BANK_DEPTH, 4096, words per bank; power of two.
- READ_LATENCY, 1, cycles from read acceptance to PortXRdValid; legal values 1 to 3.
- BANK_BITS, clog2(NUM_BANKS), localparam.
- ROW_BITS, clog2(BANK_DEPTH), localparam.
- ADDR_BITS, BANK_BITS+ROW_BITS, localparam.

Ports:
- CLK  in  1  clock.
- ASYNC_RST  in  1  asynchronous reset, active-low.
- SYNC_RST  in  1  synchronous reset, active-high.
- EN  in  1  global enable; low freezes all state.
- PortOneReqValid / PortTwoReqValid  in  1  request present.
- PortOneReqReady / PortTwoReqReady  out  1  request accepted this cycle.
- PortOneWrite / PortTwoWrite  in  1  1 = write, 0 = read.
- PortOneAddr / PortTwoAddr  in  ADDR_BITS  global word address.
- PortOneWrData / PortTwoWrData  in  DATA_WIDTH  write data.
- PortOneRdValid / PortTwoRdValid  out  1  read data valid.
- PortOneRdData / PortTwoRdData  out  DATA_WIDTH  read data.
- PortOneRdErr / PortTwoRdErr  out  1  parity error on returned word; tied 0 without the optional feature.

Behaviour:
- Address map: bank = Addr[BANK_BITS-1:0], row = Addr[ADDR_BITS-1:BANK_BITS].
- Handshake: a request transfers on a cycle where Valid && Ready. Ready is combinational from EN, SYNC_RST, both Valids, both bank indices and the RR pointer. Ready is 0 whenever EN=0 or SYNC_RST=1.
- No conflict (only one valid, or different banks): every valid port gets Ready=1. RR pointer unchanged.
- Conflict (both valid, same bank, regardless of read/write mix): only the port named by the RR pointer gets Ready. After that grant the pointer toggles to the other port. The loser must hold its request stable; it wins on the next conflicting cycle.
- RR pointer reset value selects PortOne.
- Writes: memory is updated at the acceptance clock edge. A read of the same address accepted on any later cycle returns the new data.
- Same-cycle read/write to one address cannot occur, because it is a bank conflict and is serialised. The winner executes first.
- Reads: the bank row is sampled at the acceptance edge and moves through a READ_LATENCY-deep pipeline per port. RdValid=1 with RdData exactly READ_LATENCY enabled cycles after acceptance. RdValid is a single-cycle pulse per read.
- Back-to-back reads on one port yield back-to-back RdValid pulses, one per cycle.
- RdData holds its last value when RdValid=0.
- EN=0: pipeline registers, RdValid, RdData and the RR pointer all hold. No memory writes occur. Latency is counted in EN=1 cycles only.
- Reset (ASYNC_RST low, or SYNC_RST high at an edge): RdValid=0, RdData=0, RdErr=0, pipeline valid bits=0, RR pointer=PortOne.
- Reset does not clear memory contents. In-flight reads are discarded, and no RdValid is produced for them.
- Reset asserted mid-operation: accepted-but-unreturned reads are lost silently.
- Out-of-range access is impossible, since the address fully decodes.

Optional Feature:
- UB_PARITY_EN defined: each stored word carries an extra even-parity bit computed on write. On read return, RdErr = parity mismatch, aligned with RdValid and zero when RdValid=0. Memory width becomes DATA_WIDTH+1.
- UB_PARITY_EN undefined: no parity storage, and RdErr is constant 0.

Decomposition:
- Package ub_pkg holds the port-select enum (PORT_ONE, PORT_TWO), the clog2-derived width helpers, and a read-pipeline stage struct {valid, data, err}.
- One sub-module, ub_bank: a single bank with one access port per cycle, a registered read and optional parity. It is instantiated NUM_BANKS times in a generate loop.
- Arbitration, the crossbar mux and the read pipelines live in the top module.

Test Plan:
- Write 0x5A to address 0x013 via PortOne, then read 0x013 via PortTwo on the next cycle -> PortTwoRdValid pulses READ_LATENCY cycles after acceptance with data 0x5A.
- Both ports request bank 3 for three consecutive cycles from reset -> grants go PortOne, PortTwo, PortOne; each loser sees Ready=0 and holds its request.
- PortOne reads bank 1 and PortTwo reads bank 2 together -> both Ready=1, both RdValid pulse in the same cycle, RR pointer unchanged.
- READ_LATENCY=3, issue a read, then drop EN for 2 cycles mid-flight -> RdValid appears on the 5th cycle after acceptance, with correct data.
- Issue two reads, then pull ASYNC_RST low for 1 cycle before return -> no RdValid afterwards, outputs read 0, and a prior write to 0x020 still reads back correctly.
- With UB_PARITY_EN, force-flip one stored bit at address 0x007 via hierarchical deposit, then read it -> RdErr=1 with RdValid. Reading a clean address gives RdErr=0.

Source files
------------

// File: rtl/ub_pkg.sv
// Shared types and helpers for the unified buffer: port select, width helper,
// parity helper and the read-pipeline stage record.
package ub_pkg;

  // Widest data word a pipeline stage can carry. Narrower words are zero-extended.
  localparam int UB_MAX_DW = 64;

  typedef enum logic {
    PORT_ONE = 1'b0,
    PORT_TWO = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [UB_MAX_DW-1:0] data;
    logic                 err;
  } rd_stage_t;

  function automatic int ub_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic ub_parity(input logic [UB_MAX_DW:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ub_bank.sv
// One bank of the unified buffer: a single access per cycle and a registered read.
// With UB_PARITY_EN each word stores an extra even-parity bit, checked on read.
module ub_bank
  import ub_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4096,
  localparam int ROW_BITS   = ub_bits(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  i_access,
  input  logic                  i_write,
  input  logic [ROW_BITS-1:0]   i_row,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_err
);

`ifdef UB_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  logic [MEM_W-1:0] r_mem [DEPTH];
  logic [MEM_W-1:0] r_q;
  logic [MEM_W-1:0] w_wr_word;

`ifdef UB_PARITY_EN
  assign w_wr_word = {ub_parity((UB_MAX_DW+1)'(i_wr_data)), i_wr_data};
  assign o_rd_err  = ub_parity((UB_MAX_DW+1)'(r_q));
`else
  assign w_wr_word = i_wr_data;
  assign o_rd_err  = 1'b0;
`endif

  assign o_rd_data = r_q[DATA_WIDTH-1:0];

  // Storage is never reset; the read register only moves on a read access.
  always_ff @(posedge CLK) begin
    if (i_access) begin
      if (i_write) begin
        r_mem[i_row] <= w_wr_word;
      end else begin
        r_q <= r_mem[i_row];
      end
    end
  end

endmodule

// File: rtl/unified_buffer_arb.sv
// Two-port unified buffer: interleaved banks, round-robin conflict arbitration and
// fixed-latency read return. Define UB_PARITY_EN to enable per-word parity checking.
module unified_buffer_arb
  import ub_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_BANKS    = 16,
  parameter  int BANK_DEPTH   = 4096,
  parameter  int READ_LATENCY = 1,
  localparam int BANK_BITS    = ub_bits(NUM_BANKS),
  localparam int ROW_BITS     = ub_bits(BANK_DEPTH),
  localparam int ADDR_BITS    = BANK_BITS + ROW_BITS
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  SYNC_RST,
  input  logic                  EN,
  input  logic                  PortOneReqValid,
  output logic                  PortOneReqReady,
  input  logic                  PortOneWrite,
  input  logic [ADDR_BITS-1:0]  PortOneAddr,
  input  logic [DATA_WIDTH-1:0] PortOneWrData,
  output logic                  PortOneRdValid,
  output logic [DATA_WIDTH-1:0] PortOneRdData,
  output logic                  PortOneRdErr,
  input  logic                  PortTwoReqValid,
  output logic                  PortTwoReqReady,
  input  logic                  PortTwoWrite,
  input  logic [ADDR_BITS-1:0]  PortTwoAddr,
  input  logic [DATA_WIDTH-1:0] PortTwoWrData,
  output logic                  PortTwoRdValid,
  output logic [DATA_WIDTH-1:0] PortTwoRdData,
  output logic                  PortTwoRdErr
);

  logic [1:0]            w_req_valid;
  logic [1:0]            w_write;
  logic [1:0]            w_ready;
  logic [1:0]            w_rd_valid;
  logic [1:0]            w_rd_err;
  logic [ADDR_BITS-1:0]  w_addr     [2];
  logic [DATA_WIDTH-1:0] w_wr_data  [2];
  logic [DATA_WIDTH-1:0] w_rd_data  [2];
  logic [BANK_BITS-1:0]  w_bank     [2];
  logic [ROW_BITS-1:0]   w_row      [2];
  logic                  w_go;
  logic                  w_conflict;
  port_sel_e             r_rr;
  port_sel_e             w_rr_next;

  logic [DATA_WIDTH-1:0] w_bank_rd_data [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_bank_rd_err;

  assign w_req_valid  = {PortTwoReqValid, PortOneReqValid};
  assign w_write      = {PortTwoWrite, PortOneWrite};
  assign w_addr[0]    = PortOneAddr;
  assign w_addr[1]    = PortTwoAddr;
  assign w_wr_data[0] = PortOneWrData;
  assign w_wr_data[1] = PortTwoWrData;

  assign PortOneReqReady = w_ready[0];
  assign PortTwoReqReady = w_ready[1];
  assign PortOneRdValid  = w_rd_valid[0];
  assign PortTwoRdValid  = w_rd_valid[1];
  assign PortOneRdData   = w_rd_data[0];
  assign PortTwoRdData   = w_rd_data[1];
  assign PortOneRdErr    = w_rd_err[0];
  assign PortTwoRdErr    = w_rd_err[1];

  for (genvar p = 0; p < 2; p++) begin : g_decode
    assign w_bank[p] = w_addr[p][BANK_BITS-1:0];
    assign w_row[p]  = w_addr[p][ADDR_BITS-1:BANK_BITS];
  end

  // Grant logic: only a same-bank collision consults the round-robin pointer.
  always_comb begin
    w_go       = EN & ~SYNC_RST;
    w_conflict = w_req_valid[0] & w_req_valid[1] & (w_bank[0] == w_bank[1]);
    w_ready[0] = w_go & w_req_valid[0] & (~w_conflict | (r_rr == PORT_ONE));
    w_ready[1] = w_go & w_req_valid[1] & (~w_conflict | (r_rr == PORT_TWO));
    w_rr_next  = r_rr;
    if (w_go && w_conflict) begin
      w_rr_next = (r_rr == PORT_ONE) ? PORT_TWO : PORT_ONE;
    end else begin
      w_rr_next = r_rr;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      r_rr <= PORT_ONE;
    end else if (SYNC_RST) begin
      r_rr <= PORT_ONE;
    end else begin
      r_rr <= w_rr_next;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  w_sel_one;
    logic                  w_sel_two;
    logic                  w_access;
    logic                  w_bank_write;
    logic [ROW_BITS-1:0]   w_bank_row;
    logic [DATA_WIDTH-1:0] w_bank_wr_data;

    // Crossbar: at most one granted port targets this bank in a cycle.
    always_comb begin
      w_sel_one = w_ready[0] & (w_bank[0] == BANK_BITS'(b));
      w_sel_two = w_ready[1] & (w_bank[1] == BANK_BITS'(b));
      w_access  = w_sel_one | w_sel_two;
      if (w_sel_one) begin
        w_bank_write   = w_write[0];
        w_bank_row     = w_row[0];
        w_bank_wr_data = w_wr_data[0];
      end else begin
        w_bank_write   = w_write[1];
        w_bank_row     = w_row[1];
        w_bank_wr_data = w_wr_data[1];
      end
    end

    ub_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH)
    ) u_bank (
      .CLK       (CLK),
      .i_access  (w_access),
      .i_write   (w_bank_write),
      .i_row     (w_bank_row),
      .i_wr_data (w_bank_wr_data),
      .o_rd_data (w_bank_rd_data[b]),
      .o_rd_err  (w_bank_rd_err[b])
    );
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                 r_s1_valid;
    logic [BANK_BITS-1:0] r_s1_bank;
    rd_stage_t            w_s1;

    // First read stage: the data itself sits in the bank's read register.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        r_s1_valid <= 1'b0;
        r_s1_bank  <= '0;
      end else if (SYNC_RST) begin
        r_s1_valid <= 1'b0;
        r_s1_bank  <= '0;
      end else if (EN) begin
        r_s1_valid <= w_ready[p] & ~w_write[p];
        if (w_ready[p] && !w_write[p]) begin
          r_s1_bank <= w_bank[p];
        end
      end
    end

    assign w_s1 = '{valid: r_s1_valid,
                    data:  UB_MAX_DW'(w_bank_rd_data[r_s1_bank]),
                    err:   w_bank_rd_err[r_s1_bank]};

    if (READ_LATENCY == 1) begin : g_lat1
      logic [DATA_WIDTH-1:0] r_hold;

      // Keeps the last returned word once the bank register may be reused.
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          r_hold <= '0;
        end else if (SYNC_RST) begin
          r_hold <= '0;
        end else if (EN && w_s1.valid) begin
          r_hold <= DATA_WIDTH'(w_s1.data);
        end
      end

      assign w_rd_valid[p] = w_s1.valid;
      assign w_rd_data[p]  = w_s1.valid ? DATA_WIDTH'(w_s1.data) : r_hold;
      assign w_rd_err[p]   = w_s1.valid & w_s1.err;
    end else begin : g_latn
      rd_stage_t r_stg [READ_LATENCY-1];

      // Remaining stages; data moves only with a valid word so the output holds.
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int s = 0; s < READ_LATENCY-1; s++) r_stg[s] <= '0;
        end else if (SYNC_RST) begin
          for (int s = 0; s < READ_LATENCY-1; s++) r_stg[s] <= '0;
        end else if (EN) begin
          r_stg[0].valid <= w_s1.valid;
          if (w_s1.valid) begin
            r_stg[0].data <= w_s1.data;
            r_stg[0].err  <= w_s1.err;
          end
          for (int s = 1; s < READ_LATENCY-1; s++) begin
            r_stg[s].valid <= r_stg[s-1].valid;
            if (r_stg[s-1].valid) begin
              r_stg[s].data <= r_stg[s-1].data;
              r_stg[s].err  <= r_stg[s-1].err;
            end
          end
        end
      end

      assign w_rd_valid[p] = r_stg[READ_LATENCY-2].valid;
      assign w_rd_data[p]  = DATA_WIDTH'(r_stg[READ_LATENCY-2].data);
      assign w_rd_err[p]   = r_stg[READ_LATENCY-2].valid & r_stg[READ_LATENCY-2].err;
    end
  end

endmodule
